// File: rtl/rom_port_arbiter.sv
// -----------------------------------------------------------------------------
// rom_port_arbiter
//
// Sequences ROM loading and shares one synchronous ROM/BRAM port between the
// HPS download stream and the game core's read port.
//
// The flat download/core address is decoded into four one-hot region selects.
// The region-relative address is driven on mem_addr. Download bytes pass
// through a one-entry write buffer, and dn_wait gives backpressure. The game
// core is held in reset from power-up until a download has drained. After
// that comes a fixed guard interval of HOLD_CYCLES clocks.
//
// Ports
//   CLK, RESET_N        system clock, asynchronous active-low reset
//   dn_download         download window active
//   dn_wr/addr/data     one-cycle download byte strobe, flat address, byte
//   dn_wait             buffer full: dn_wr must not be issued
//   core_rd/core_addr   one-cycle core read request and flat address
//   core_data/valid     read data with a one-cycle valid pulse
//   mem_cs/addr/din/we  shared memory port (one-hot region select)
//   mem_dout            memory read data, valid one cycle after mem_cs
//   core_reset          active-high reset to the game core
//   dl_sum, dl_bytes    mod-256 byte sum and byte count of the last download
//   err_overflow        sticky: dn_wr arrived while dn_wait was high
// -----------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] REG1_BASE   = 16'h8000,
  parameter logic [ADDR_W-1:0] REG2_BASE   = 16'hA000,
  parameter logic [ADDR_W-1:0] REG3_BASE   = 16'hC000,
  parameter int unsigned       HOLD_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  output logic              dn_wait,
  input  logic              core_rd,
  input  logic [ADDR_W-1:0] core_addr,
  output logic [7:0]        core_data,
  output logic              core_valid,
  output logic [3:0]        mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  output logic              core_reset,
  output logic [7:0]        dl_sum,
  output logic [ADDR_W:0]   dl_bytes,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  localparam logic [7:0]      HOLD_LOAD = 8'(HOLD_CYCLES);
  localparam logic [ADDR_W:0] BYTES_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] BYTES_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // One-hot region select for a flat address.
  function automatic logic [3:0] region_cs(input logic [ADDR_W-1:0] addr);
    logic [3:0] cs;
    if (addr < REG1_BASE)      cs = 4'b0001;
    else if (addr < REG2_BASE) cs = 4'b0010;
    else if (addr < REG3_BASE) cs = 4'b0100;
    else                       cs = 4'b1000;
    return cs;
  endfunction

  // Region-relative offset of a flat address.
  function automatic logic [ADDR_W-1:0] region_off(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    if (addr < REG1_BASE)      off = addr;
    else if (addr < REG2_BASE) off = addr - REG1_BASE;
    else if (addr < REG3_BASE) off = addr - REG2_BASE;
    else                       off = addr - REG3_BASE;
    return off;
  endfunction

  state_t            state_r, state_next_s;
  logic [7:0]        hold_cnt_r;
  logic              buf_full_r;
  logic [3:0]        buf_cs_r;
  logic [ADDR_W-1:0] buf_addr_r;
  logic [7:0]        buf_data_r;
  logic              rd_s1_r, rd_s2_r;
  logic              read_grant_s, drain_s, wr_accept_s, wr_drop_s;
  logic              load_entry_s, keep_rd_s;

  logic [3:0]        mem_cs_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_din_r, core_data_r, dl_sum_r;
  logic              mem_we_r, core_valid_r, core_reset_r, err_overflow_r;
  logic [ADDR_W:0]   dl_bytes_r;

  // Port grant and write-buffer flow: a core read in RUN wins over a drain.
  // A drain in the same cycle frees the slot for an incoming byte.
  always_comb begin
    read_grant_s = 1'b0;
    drain_s      = 1'b0;
    wr_accept_s  = 1'b0;
    wr_drop_s    = 1'b0;
    keep_rd_s    = 1'b0;
    read_grant_s = (state_r == ST_RUN) && core_rd;
    drain_s      = buf_full_r && !read_grant_s;
    wr_accept_s  = dn_wr && (!buf_full_r || drain_s);
    wr_drop_s    = dn_wr && buf_full_r && !drain_s;
    // A read survives only while the FSM stays in RUN with no new download.
    keep_rd_s    = (state_r == ST_RUN) && !dn_download;
  end

  // Next-state decode for the load sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (dn_download) state_next_s = ST_LOAD;
        else             state_next_s = ST_IDLE;
      end
      ST_LOAD: begin
        // The last byte must reach memory before the guard interval starts.
        if (!dn_download && !buf_full_r && !dn_wr) state_next_s = ST_HOLD;
        else                                       state_next_s = ST_LOAD;
      end
      ST_HOLD: begin
        if (dn_download)               state_next_s = ST_LOAD;
        else if (hold_cnt_r == 8'd1)   state_next_s = ST_RUN;
        else                           state_next_s = ST_HOLD;
      end
      ST_RUN: begin
        if (dn_download) state_next_s = ST_LOAD;
        else             state_next_s = ST_RUN;
      end
      default: state_next_s = ST_IDLE;
    endcase
    load_entry_s = (state_next_s == ST_LOAD) && (state_r != ST_LOAD);
  end

  // Sequencer state, guard counter and core reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= 8'd0;
      core_reset_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      core_reset_r <= (state_next_s != ST_RUN);
      if (state_next_s == ST_HOLD && state_r != ST_HOLD) hold_cnt_r <= HOLD_LOAD;
      else if (state_r == ST_HOLD)                       hold_cnt_r <= hold_cnt_r - 8'd1;
      else                                               hold_cnt_r <= hold_cnt_r;
    end
  end

  // One-entry write buffer, download statistics and overflow flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      buf_full_r     <= 1'b0;
      buf_cs_r       <= 4'b0000;
      buf_addr_r     <= {ADDR_W{1'b0}};
      buf_data_r     <= 8'h00;
      dl_sum_r       <= 8'h00;
      dl_bytes_r     <= {(ADDR_W+1){1'b0}};
      err_overflow_r <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        buf_full_r <= 1'b1;
        buf_cs_r   <= region_cs(dn_addr);
        buf_addr_r <= region_off(dn_addr);
        buf_data_r <= dn_data;
      end else if (drain_s) begin
        buf_full_r <= 1'b0;
      end
      // A byte accepted on the entry edge belongs to the new download.
      if (load_entry_s) begin
        dl_sum_r   <= wr_accept_s ? dn_data : 8'h00;
        dl_bytes_r <= wr_accept_s ? BYTES_ONE : {(ADDR_W+1){1'b0}};
      end else if (wr_accept_s) begin
        dl_sum_r <= dl_sum_r + dn_data;
        if (dl_bytes_r != BYTES_MAX) dl_bytes_r <= dl_bytes_r + BYTES_ONE;
      end
      if (wr_drop_s) err_overflow_r <= 1'b1;
    end
  end

  // Shared memory port and the two-stage read return pipeline.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_cs_r     <= 4'b0000;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_din_r    <= 8'h00;
      mem_we_r     <= 1'b0;
      rd_s1_r      <= 1'b0;
      rd_s2_r      <= 1'b0;
      core_valid_r <= 1'b0;
      core_data_r  <= 8'h00;
    end else begin
      if (read_grant_s) begin
        mem_cs_r   <= region_cs(core_addr);
        mem_addr_r <= region_off(core_addr);
        mem_we_r   <= 1'b0;
      end else if (drain_s) begin
        mem_cs_r   <= buf_cs_r;
        mem_addr_r <= buf_addr_r;
        mem_din_r  <= buf_data_r;
        mem_we_r   <= 1'b1;
      end else begin
        mem_cs_r   <= 4'b0000;
        mem_we_r   <= 1'b0;
      end
      // s1: address on the port; s2: mem_dout valid; then capture.
      rd_s1_r      <= read_grant_s;
      rd_s2_r      <= rd_s1_r && keep_rd_s;
      core_valid_r <= rd_s2_r && keep_rd_s;
      if (rd_s2_r && keep_rd_s) core_data_r <= mem_dout;
    end
  end

  assign dn_wait      = buf_full_r;
  assign mem_cs       = mem_cs_r;
  assign mem_addr     = mem_addr_r;
  assign mem_din      = mem_din_r;
  assign mem_we       = mem_we_r;
  assign core_data    = core_data_r;
  assign core_valid   = core_valid_r;
  assign core_reset   = core_reset_r;
  assign dl_sum       = dl_sum_r;
  assign dl_bytes     = dl_bytes_r;
  assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed steps plus randomized
// download/read traffic, compared against a flat-address ROM model.
module tb_rom_port_arbiter;
  localparam int AW   = 16;
  localparam int HOLD = 16;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          dn_download = 1'b0, dn_wr = 1'b0, core_rd = 1'b0;
  logic [AW-1:0] dn_addr = '0, core_addr = '0;
  logic [7:0]    dn_data = 8'h00;
  logic          dn_wait, core_valid, mem_we, core_reset, err_overflow;
  logic [7:0]    core_data, mem_din, dl_sum;
  logic [7:0]    mem_dout = 8'h00;
  logic [3:0]    mem_cs;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   dl_bytes;

  always #5 CLK = ~CLK;

  rom_port_arbiter #(
    .ADDR_W(AW), .REG1_BASE(16'h8000), .REG2_BASE(16'hA000),
    .REG3_BASE(16'hC000), .HOLD_CYCLES(HOLD)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .dn_download(dn_download), .dn_wr(dn_wr),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wait(dn_wait), .core_rd(core_rd),
    .core_addr(core_addr), .core_data(core_data), .core_valid(core_valid),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .core_reset(core_reset), .dl_sum(dl_sum),
    .dl_bytes(dl_bytes), .err_overflow(err_overflow)
  );

  // Synchronous memory behind the port: four banks selected by one-hot cs.
  logic [7:0] bmem [0:4*65536-1];
  function automatic int ridx(input logic [3:0] cs);
    case (cs)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction
  always @(posedge CLK) begin
    if (mem_cs != 4'b0000) begin
      if (mem_we) begin
        if (ridx(mem_cs) >= 0) bmem[ridx(mem_cs)*65536 + int'(mem_addr)] <= mem_din;
      end else begin
        mem_dout <= (ridx(mem_cs) >= 0) ? bmem[ridx(mem_cs)*65536 + int'(mem_addr)] : 8'hEE;
      end
    end
  end

  // Reference model: ROM contents by flat address, download statistics.
  logic [7:0]  ref_rom [0:65535];
  logic [15:0] wl[$];
  int          exp_sum = 0, exp_bytes = 0;
  int          checks = 0, errors = 0;

  function automatic logic [3:0] exp_cs(input logic [15:0] a);
    if (a < 16'h8000) return 4'b0001;
    if (a < 16'hA000) return 4'b0010;
    if (a < 16'hC000) return 4'b0100;
    return 4'b1000;
  endfunction
  function automatic logic [15:0] exp_off(input logic [15:0] a);
    if (a < 16'h8000) return a;
    if (a < 16'hA000) return a - 16'h8000;
    if (a < 16'hC000) return a - 16'hA000;
    return a - 16'hC000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Protocol-abiding download byte; checks the drain on the following edge.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    check("wr_idle_wait", 32'(dn_wait), 32'd0);
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    tick();
    dn_wr = 1'b0;
    ref_rom[a] = d; wl.push_back(a);
    exp_sum = (exp_sum + int'(d)) & 255; exp_bytes++;
    check("wr_wait_hi", 32'(dn_wait), 32'd1);
    tick();
    check("drain_we", 32'(mem_we), 32'd1);
    check("drain_cs", 32'(mem_cs), 32'(exp_cs(a)));
    check("drain_addr", 32'(mem_addr), 32'(exp_off(a)));
    check("drain_din", 32'(mem_din), 32'(d));
    check("drain_wait_lo", 32'(dn_wait), 32'd0);
  endtask

  // Caller has dropped dn_download with the buffer empty.
  task automatic wait_release(input string tag);
    int n;
    tick();
    check({tag, "_entry_rst"}, 32'(core_reset), 32'd1);
    n = 0;
    while (core_reset === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_len"}, 32'(n), 32'(HOLD));
  endtask

  // n read slots (all issued or random); each read returns 2 edges later.
  task automatic read_burst(input int n, input bit rand_en);
    bit          hv[$];
    logic [15:0] ha[$];
    bit          en, ev;
    logic [15:0] a;
    for (int c = 0; c < n + 2; c++) begin
      en = 1'b0; a = 16'h0000;
      if (c < n) begin
        en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        a  = wl[$urandom_range(0, wl.size() - 1)];
      end
      core_rd = en; core_addr = a;
      tick();
      hv.push_back(en); ha.push_back(a);
      ev = (c >= 2) ? hv[c-2] : 1'b0;
      check("rd_valid", 32'(core_valid), 32'(ev));
      if (ev) check("rd_data", 32'(core_data), 32'(ref_rom[ha[c-2]]));
    end
    core_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    // Reset values
    #12;
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_dn_wait", 32'(dn_wait), 32'd0);
    check("rst_mem_cs", 32'(mem_cs), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_core_valid", 32'(core_valid), 32'd0);
    check("rst_core_data", 32'(core_data), 32'd0);
    check("rst_dl_sum", 32'(dl_sum), 32'd0);
    check("rst_dl_bytes", 32'(dl_bytes), 32'd0);
    check("rst_err", 32'(err_overflow), 32'd0);
    RESET_N = 1'b1;
    repeat (20) tick();
    check("idle_core_reset", 32'(core_reset), 32'd1);
    check("idle_mem_cs", 32'(mem_cs), 32'd0);

    // Region decode download
    dn_download = 1'b1;
    tick();
    do_write(16'h0000, 8'h11);
    do_write(16'h8001, 8'h22);
    do_write(16'hA002, 8'h33);
    do_write(16'hFFFF, 8'h44);
    check("dl_sum_aa", 32'(dl_sum), 32'(exp_sum));
    check("dl_bytes_4", 32'(dl_bytes), 32'(exp_bytes));

    // Release timing
    dn_download = 1'b0;
    wait_release("hold1");

    // Read latency
    core_rd = 1'b1; core_addr = 16'h8001;
    tick();
    core_rd = 1'b0;
    check("rd_mem_cs", 32'(mem_cs), 32'b0010);
    check("rd_mem_addr", 32'(mem_addr), 32'h0001);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    tick();
    check("rd_lat_n1", 32'(core_valid), 32'd0);
    tick();
    check("rd_lat_n2", 32'(core_valid), 32'd1);
    check("rd_lat_data", 32'(core_data), 32'(ref_rom[16'h8001]));
    tick();
    check("rd_lat_n3", 32'(core_valid), 32'd0);
    read_burst(4, 1'b0);

    // Overflow while reads hold the port
    core_rd = 1'b1; core_addr = 16'h0000;
    dn_wr = 1'b1; dn_addr = 16'h1234; dn_data = 8'h5A;
    tick();
    exp_sum = (exp_sum + 32'h5A) & 255; exp_bytes++;
    check("ovf_wait", 32'(dn_wait), 32'd1);
    check("ovf_err_pre", 32'(err_overflow), 32'd0);
    core_addr = 16'h8001; dn_addr = 16'h1235; dn_data = 8'hA5;
    tick();
    core_rd = 1'b0; dn_wr = 1'b0;
    check("ovf_err", 32'(err_overflow), 32'd1);
    check("ovf_bytes", 32'(dl_bytes), 32'(exp_bytes));
    check("ovf_sum", 32'(dl_sum), 32'(exp_sum));
    check("ovf_no_drain", 32'(mem_we), 32'd0);
    tick();
    check("ovf_drain_we", 32'(mem_we), 32'd1);
    check("ovf_drain_din", 32'(mem_din), 32'h5A);
    check("ovf_drain_addr", 32'(mem_addr), 32'h1234);
    check("ovf_rd0_valid", 32'(core_valid), 32'd1);
    check("ovf_rd0_data", 32'(core_data), 32'(ref_rom[16'h0000]));
    ref_rom[16'h1234] = 8'h5A; wl.push_back(16'h1234);
    tick();
    check("ovf_rd1_valid", 32'(core_valid), 32'd1);
    check("ovf_rd1_data", 32'(core_data), 32'(ref_rom[16'h8001]));
    check("ovf_wait_lo", 32'(dn_wait), 32'd0);

    // Re-download mid-RUN
    core_rd = 1'b1; core_addr = 16'h8001;
    tick();
    core_rd = 1'b0; dn_download = 1'b1;
    tick();
    exp_sum = 0; exp_bytes = 0;
    check("redl_core_reset", 32'(core_reset), 32'd1);
    check("redl_sum", 32'(dl_sum), 32'(exp_sum));
    check("redl_bytes", 32'(dl_bytes), 32'(exp_bytes));
    tick();
    check("redl_no_valid_a", 32'(core_valid), 32'd0);
    tick();
    check("redl_no_valid_b", 32'(core_valid), 32'd0);

    // Randomized download
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 65535));
      do_write(ra, 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    check("rnd_sum", 32'(dl_sum), 32'(exp_sum));
    check("rnd_bytes", 32'(dl_bytes), 32'(exp_bytes));
    dn_download = 1'b0;
    wait_release("hold2");

    // Randomized reads
    read_burst(60, 1'b1);
    check("err_sticky", 32'(err_overflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Sequences ROM loading and shares one synchronous ROM/BRAM port between the HPS download stream and the game core's read port. It decodes flat download addresses into four one-hot region selects and buffers one download write with backpressure. It holds the game core in reset from power-up until a download completes, plus a fixed guard interval. It sits between hps_io's ioctl signals and the arcade core's ROM read interface.

## Interface
Parameters:
- ADDR_W, 16, width of flat download/core address
- REG1_BASE, 16'h8000, first address of region 1 (region 0 is 0..REG1_BASE-1)
- REG2_BASE, 16'hA000, first address of region 2
- REG3_BASE, 16'hC000, first address of region 3 (extends to top of address space)
- HOLD_CYCLES, 16, CLK cycles core_reset stays high after download ends (1..255)

Ports:
- CLK  in  1  system clock, single clock domain
- RESET_N  in  1  asynchronous, active-low reset
- dn_download  in  1  download window active
- dn_wr  in  1  download byte strobe, one cycle
- dn_addr  in  ADDR_W  flat download address
- dn_data  in  8  download byte
- dn_wait  out  1  backpressure: high = dn_wr must not be issued
- core_rd  in  1  core read request, one cycle
- core_addr  in  ADDR_W  flat core read address
- core_data  out  8  read data
- core_valid  out  1  one-cycle pulse, core_data valid
- mem_cs  out  4  one-hot region select (0 = idle)
- mem_addr  out  ADDR_W  region-relative address (flat address minus region base)
- mem_din  out  8  write data
- mem_we  out  1  write enable
- mem_dout  in  8  memory read data, valid one cycle after mem_cs
- core_reset  out  1  active-high reset to game core
- dl_sum  out  8  modulo-256 sum of bytes accepted in last download
- dl_bytes  out  ADDR_W+1  byte count of last download
- err_overflow  out  1  sticky: dn_wr arrived while dn_wait high

## Operation
- FSM states: IDLE, LOAD, HOLD, RUN.
- IDLE (after reset): core_reset=1. Moves to LOAD on dn_download=1. Never goes to RUN directly, because the ROM is empty.
- LOAD: core_reset=1. Entry clears dl_sum and dl_bytes. Each accepted dn_wr loads the one-entry write buffer, adds dn_data to dl_sum and increments dl_bytes.
  - Leaves for HOLD when dn_download=0 and the buffer is empty.
  - If dn_download falls while the buffer is full, the FSM stays in LOAD until the buffer drains.
- HOLD: core_reset=1. Counter loads HOLD_CYCLES on entry and decrements every cycle; moves to RUN when the counter reaches 0. dn_download=1 returns the FSM to LOAD.
- RUN: core_reset=0. dn_download=1 moves to LOAD; core_reset rises the next cycle; any in-flight read is discarded (no core_valid).
- Port grant, one owner per cycle:
  - In RUN, a sampled core_rd owns the port.
  - Otherwise, a full write buffer drains: mem_we=1 with the buffer's cs, addr and data.
  - core_rd outside RUN is ignored.
- Region decode, applied identically to write and read addresses:
  - addr < REG1_BASE -> cs=0001
  - addr < REG2_BASE -> cs=0010
  - addr < REG3_BASE -> cs=0100
  - otherwise cs=1000
- Buffer flow: dn_wait = buffer full. A drain and a new dn_wr in the same cycle are both accepted. A dn_wr while dn_wait=1 is dropped and sets err_overflow; err_overflow clears only on reset.
- dl_sum wraps mod 256. dl_bytes saturates at 2^ADDR_W.

## Timing
- Reset values: state=IDLE, core_reset=1, dn_wait=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, core_valid=0, core_data=0, dl_sum=0, dl_bytes=0, err_overflow=0, buffer empty.
- All outputs are registered except dn_wait, which is decoded from buffer state.
- Write: dn_wr sampled at edge N, with no core read in N+1 -> mem_we/mem_cs high during cycle N+1, one cycle. dn_wait is high from N+1 until the drain edge.
- Read: core_rd sampled at edge N -> mem_cs/mem_addr during N+1 -> mem_dout captured at edge N+2 -> core_valid=1 and core_data valid during N+2..N+3, one cycle. Back-to-back reads run at one per cycle.
- HOLD length: exactly HOLD_CYCLES cycles with core_reset=1 after the buffer drains and dn_download=0.

## Test plan
- Reset then idle: RESET_N low -> all outputs at reset values; core_reset stays 1 indefinitely with no download.
- Region decode: download bytes 0x11@0x0000, 0x22@0x8001, 0x33@0xA002, 0x44@0xFFFF -> mem_cs 0001/0010/0100/1000 with mem_addr 0x0000/0x0001/0x0002/0x3FFF; after the download, dl_sum=0xAA, dl_bytes=4.
- Release timing: dn_download falls with the buffer empty, HOLD_CYCLES=16 -> core_reset falls exactly 16 cycles after HOLD entry.
- Read latency: in RUN, core_rd at 0x8001 -> core_valid one cycle, core_data=0x22, two cycles after sampling; 4 back-to-back reads give 4 consecutive valid pulses.
- Overflow: two dn_wr on consecutive cycles while a core read holds the port -> second byte dropped, err_overflow=1, dl_bytes counts only the first byte.
- Re-download mid-RUN: dn_download rises one cycle after core_rd -> no core_valid, core_reset=1 on the next cycle, dl_sum/dl_bytes cleared.
